// File: rtl/sh7604_ibus_master.sv
// SH7604 IBUS initiator: CPU load/store to on-chip peripheral bus.
// Lane steering, busy wait, misalign / unmapped / timeout reporting.
module sh7604_ibus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_BUSY,
  output logic        CPU_ACK,
  output logic        ADDR_ERR,
  output logic        BUS_ERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic [31:0] IBUS_DO,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t state_q, state_d;

  logic        adv;
  logic        unused_ce_f;
  logic        mis;
  logic        hit;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  sz_q, sz_d;
  logic [1:0]  off_q, off_d;
  logic        lwe_q, lwe_d;
  logic [3:0]  ba_new;
  logic [31:0] di_new;
  logic [31:0] rd;
  logic [31:0] sh;

  logic [31:0] do_q, do_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        aerr_q, aerr_d;
  logic        berr_q, berr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] di_q, di_d;
  logic [3:0]  ba_q, ba_d;
  logic        we_q, we_d;
  logic        req_q, req_d;

  // Peripherals use the falling phase; the initiator only needs CE_R.
  assign unused_ce_f = CE_F;
  assign adv     = EN & CE_R;
  assign cnt_inc = cnt_q + 8'd1;
  assign hit     = (cnt_inc == TO);
  assign mis     = CPU_SZ[1] ? |CPU_A[1:0]
                             : (CPU_SZ[0] & CPU_A[0]);

  always_comb begin
    ba_new = 4'b1111;
    di_new = CPU_DI;
    unique case (1'b1)
      (CPU_SZ == 2'd0): begin
        ba_new = 4'b1000 >> CPU_A[1:0];
        di_new = {4{CPU_DI[7:0]}};
      end
      (CPU_SZ == 2'd1): begin
        ba_new = CPU_A[1] ? 4'b0011 : 4'b1100;
        di_new = {2{CPU_DI[15:0]}};
      end
      CPU_SZ[1]: begin
        ba_new = 4'b1111;
        di_new = CPU_DI;
      end
    endcase
  end

  assign sh = IBUS_DO >> {~off_q, 3'b000};

  always_comb begin
    rd = IBUS_DO;
    unique case (1'b1)
      (sz_q == 2'd0): rd = {24'd0, sh[7:0]};
      (sz_q == 2'd1): rd = off_q[1] ? {16'd0, IBUS_DO[15:0]}
                                    : {16'd0, IBUS_DO[31:16]};
      sz_q[1]:        rd = IBUS_DO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)      state_q <= IDLE;
    else if (adv) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (CPU_REQ) state_d = mis ? DONE : ACCESS;
      ACCESS:
        if (!IBUS_ACT || !IBUS_BUSY || hit)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    do_d   = do_q;
    busy_d = busy_q;
    ack_d  = ack_q;
    aerr_d = aerr_q;
    berr_d = berr_q;
    a_d    = a_q;
    di_d   = di_q;
    ba_d   = ba_q;
    we_d   = we_q;
    req_d  = req_q;
    cnt_d  = cnt_q;
    sz_d   = sz_q;
    off_d  = off_q;
    lwe_d  = lwe_q;
    unique case (state_q)
      IDLE: if (CPU_REQ) begin
        busy_d = 1'b1;
        sz_d   = CPU_SZ;
        off_d  = CPU_A[1:0];
        lwe_d  = CPU_WE;
        if (mis) begin
          ack_d  = 1'b1;
          aerr_d = 1'b1;
          do_d   = '0;
        end else begin
          a_d   = CPU_A;
          di_d  = di_new;
          ba_d  = ba_new;
          we_d  = CPU_WE;
          req_d = 1'b1;
          cnt_d = '0;
        end
      end
      ACCESS: begin
        if (!IBUS_ACT) begin
          req_d  = 1'b0;
          ack_d  = 1'b1;
          berr_d = 1'b1;
          do_d   = '0;
        end else if (!IBUS_BUSY) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          ba_d  = '0;
          ack_d = 1'b1;
          if (!lwe_q) do_d = rd;
        end else begin
          cnt_d = cnt_inc;
          if (hit) begin
            req_d  = 1'b0;
            ack_d  = 1'b1;
            berr_d = 1'b1;
            do_d   = '0;
          end
        end
      end
      DONE: begin
        ack_d  = 1'b0;
        busy_d = 1'b0;
        aerr_d = 1'b0;
        berr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_q   <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      aerr_q <= 1'b0;
      berr_q <= 1'b0;
      a_q    <= '0;
      di_q   <= '0;
      ba_q   <= '0;
      we_q   <= 1'b0;
      req_q  <= 1'b0;
      cnt_q  <= '0;
      sz_q   <= '0;
      off_q  <= '0;
      lwe_q  <= 1'b0;
    end else if (adv) begin
      do_q   <= do_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
      aerr_q <= aerr_d;
      berr_q <= berr_d;
      a_q    <= a_d;
      di_q   <= di_d;
      ba_q   <= ba_d;
      we_q   <= we_d;
      req_q  <= req_d;
      cnt_q  <= cnt_d;
      sz_q   <= sz_d;
      off_q  <= off_d;
      lwe_q  <= lwe_d;
    end
  end

  assign CPU_DO   = do_q;
  assign CPU_BUSY = busy_q;
  assign CPU_ACK  = ack_q;
  assign ADDR_ERR = aerr_q;
  assign BUS_ERR  = berr_q;
  assign IBUS_A   = a_q;
  assign IBUS_DI  = di_q;
  assign IBUS_BA  = ba_q;
  assign IBUS_WE  = we_q;
  assign IBUS_REQ = req_q;

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Bench for sh7604_ibus_master: vector table, random transactions
// against a transaction-level model, plus reset / enable sequences.
module tb_sh7604_ibus_master;

  logic        CLK = 1'b0;
  logic        RST, CE_R, CE_F, EN;
  logic [31:0] CPU_A, CPU_DI, IBUS_DO;
  logic [1:0]  CPU_SZ;
  logic        CPU_WE, CPU_REQ, IBUS_BUSY, IBUS_ACT;
  bit          sel;

  logic        req0, req1;
  logic [31:0] do0, do1, a0, a1, di0, di1;
  logic        busy0, busy1, ack0, ack1;
  logic        aerr0, aerr1, berr0, berr1;
  logic [3:0]  ba0, ba1;
  logic        we0, we1, ireq0, ireq1;

  logic [31:0] o_do, o_a, o_di;
  logic [3:0]  o_ba;
  logic        o_busy, o_ack, o_aerr, o_berr, o_we, o_req;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hold [2];

  always #5 CLK = ~CLK;

  assign req0 = CPU_REQ & ~sel;
  assign req1 = CPU_REQ & sel;

  assign o_do   = sel ? do1 : do0;
  assign o_a    = sel ? a1 : a0;
  assign o_di   = sel ? di1 : di0;
  assign o_ba   = sel ? ba1 : ba0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_ack  = sel ? ack1 : ack0;
  assign o_aerr = sel ? aerr1 : aerr0;
  assign o_berr = sel ? berr1 : berr0;
  assign o_we   = sel ? we1 : we0;
  assign o_req  = sel ? ireq1 : ireq0;

  sh7604_ibus_master #(.TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_SZ(CPU_SZ),
    .CPU_WE(CPU_WE), .CPU_REQ(req0),
    .CPU_DO(do0), .CPU_BUSY(busy0), .CPU_ACK(ack0),
    .ADDR_ERR(aerr0), .BUS_ERR(berr0),
    .IBUS_A(a0), .IBUS_DI(di0), .IBUS_BA(ba0),
    .IBUS_WE(we0), .IBUS_REQ(ireq0),
    .IBUS_DO(IBUS_DO), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
  );

  sh7604_ibus_master #(.TIMEOUT(4)) dut4 (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_SZ(CPU_SZ),
    .CPU_WE(CPU_WE), .CPU_REQ(req1),
    .CPU_DO(do1), .CPU_BUSY(busy1), .CPU_ACK(ack1),
    .ADDR_ERR(aerr1), .BUS_ERR(berr1),
    .IBUS_A(a1), .IBUS_DI(di1), .IBUS_BA(ba1),
    .IBUS_WE(we1), .IBUS_REQ(ireq1),
    .IBUS_DO(IBUS_DO), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    bit          we;
    logic [31:0] di;
    int          busy_n;
    bit          act;
    logic [31:0] dov;
    bit          sel;
    logic [3:0]  e_ba;
    logic [31:0] e_di;
    int          e_req;
    bit          e_aerr;
    bit          e_berr;
    logic [31:0] e_do;
  } rec_t;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One CE_R period: rising-phase edge then falling-phase edge.
  task automatic tick(bit ce);
    CE_R = ce;
    CE_F = 1'b0;
    @(posedge CLK);
    #1;
    CE_R = 1'b0;
    CE_F = ce;
    @(posedge CLK);
    #1;
  endtask

  function automatic rec_t mk(logic [31:0] a, logic [1:0] sz, bit we,
      logic [31:0] di, int busy_n, bit act, logic [31:0] dov, bit s,
      logic [3:0] eba, logic [31:0] edi, int ereq, bit eae, bit ebe,
      logic [31:0] edo);
    rec_t r;
    r.a = a; r.sz = sz; r.we = we; r.di = di; r.busy_n = busy_n;
    r.act = act; r.dov = dov; r.sel = s; r.e_ba = eba; r.e_di = edi;
    r.e_req = ereq; r.e_aerr = eae; r.e_berr = ebe; r.e_do = edo;
    return r;
  endfunction

  // Transaction-level model: byte span, replication, lane extraction.
  function automatic rec_t model(rec_t r, logic [31:0] h);
    int n, off, t;
    bit mis;
    logic [31:0] mask;
    n    = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
    off  = int'(r.a[1:0]);
    t    = r.sel ? 4 : 255;
    mis  = (off % n) != 0;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    r.e_ba = '0;
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + n) r.e_ba[3-k] = 1'b1;
    r.e_di = (n == 1) ? (r.di & mask) * 32'h0101_0101 :
             (n == 2) ? (r.di & mask) * 32'h0001_0001 : r.di;
    r.e_aerr = mis;
    r.e_berr = !mis && (!r.act || r.busy_n >= t);
    r.e_req  = mis ? 0 : !r.act ? 1 : (r.busy_n >= t) ? t : r.busy_n + 1;
    if (mis || r.e_berr) r.e_do = '0;
    else if (r.we)       r.e_do = h;
    else                 r.e_do = (r.dov >> (8 * (4 - off - n))) & mask;
    return r;
  endfunction

  task automatic run(rec_t r, string tag);
    int reqp = 0;
    int acks = 0;
    bit first = 1'b1;
    bit stable = 1'b1;
    bit got = 1'b0;
    logic [31:0] fa = '0, fdi = '0, fdo = '0;
    logic [3:0] fba = '0;
    logic fwe = 1'b0, fae = 1'b0, fbe = 1'b0;
    sel = r.sel;
    CPU_A = r.a; CPU_SZ = r.sz; CPU_WE = r.we; CPU_DI = r.di;
    IBUS_ACT = r.act; IBUS_DO = r.dov; IBUS_BUSY = 1'b0;
    CPU_REQ = 1'b1;
    tick(1);
    chk({tag, " busy"}, 32'(o_busy), 32'd1);
    for (int s = 1; s <= 400; s++) begin
      if (o_req) begin
        if (first) begin
          fa = o_a; fdi = o_di; fba = o_ba; fwe = o_we; first = 1'b0;
        end else if (o_a !== fa || o_di !== fdi || o_ba !== fba)
          stable = 1'b0;
        reqp++;
      end
      if (o_ack) begin
        acks++; got = 1'b1;
        fae = o_aerr; fbe = o_berr; fdo = o_do;
        break;
      end
      IBUS_BUSY = (s <= r.busy_n);
      tick(1);
    end
    if (!got) chk({tag, " ack_timeout"}, 32'd0, 32'd1);
    if (!r.e_aerr && !r.e_berr)
      chk({tag, " drop"}, {26'd0, o_req, o_we, o_ba}, 32'd0);
    CPU_REQ = 1'b0;
    IBUS_BUSY = 1'b0;
    tick(1);
    chk({tag, " ack_clear"}, {28'd0, o_ack, o_busy, o_aerr, o_berr}, 32'd0);
    chk({tag, " req_periods"}, reqp, r.e_req);
    chk({tag, " acks"}, acks, 1);
    chk({tag, " addr_err"}, 32'(fae), 32'(r.e_aerr));
    chk({tag, " bus_err"}, 32'(fbe), 32'(r.e_berr));
    chk({tag, " cpu_do"}, fdo, r.e_do);
    if (r.e_req > 0) begin
      chk({tag, " ibus_a"}, fa, r.a);
      chk({tag, " ibus_ba"}, 32'(fba), 32'(r.e_ba));
      chk({tag, " ibus_di"}, fdi, r.e_di);
      chk({tag, " ibus_we"}, 32'(fwe), 32'(r.we));
      chk({tag, " stable"}, 32'(stable), 32'd1);
    end
    hold[r.sel] = r.e_do;
  endtask

  rec_t tbl [12];
  rec_t rr;
  int acks_seen;

  initial begin
    RST = 1'b1; EN = 1'b1; CE_R = 1'b0; CE_F = 1'b0; sel = 1'b0;
    CPU_A = '0; CPU_DI = '0; CPU_SZ = '0; CPU_WE = 1'b0; CPU_REQ = 1'b0;
    IBUS_DO = '0; IBUS_BUSY = 1'b0; IBUS_ACT = 1'b1;
    hold[0] = '0; hold[1] = '0;
    tick(1);
    tick(1);
    RST = 1'b0;
    chk("reset_dut", 32'(|{do0, busy0, ack0, aerr0, berr0, a0, di0,
        ba0, we0, ireq0}), 32'd0);
    chk("reset_dut4", 32'(|{do1, busy1, ack1, aerr1, berr1, a1, di1,
        ba1, we1, ireq1}), 32'd0);

    tbl[0]  = mk(32'hFFFF_FF00, 2, 1, 32'h1234_5678, 0, 1, 32'h0, 0,
                 4'b1111, 32'h1234_5678, 1, 0, 0, 32'h0);
    tbl[1]  = mk(32'hFFFF_FF03, 0, 0, 32'h0, 0, 1, 32'h1122_3344, 0,
                 4'b0001, 32'h0, 1, 0, 0, 32'h44);
    tbl[2]  = mk(32'hFFFF_FF00, 1, 0, 32'h0, 0, 1, 32'h1122_3344, 0,
                 4'b1100, 32'h0, 1, 0, 0, 32'h1122);
    tbl[3]  = mk(32'hFFFF_FF02, 1, 1, 32'h0000_BEEF, 0, 1, 32'h0, 0,
                 4'b0011, 32'hBEEF_BEEF, 1, 0, 0, 32'h1122);
    tbl[4]  = mk(32'hFFFF_FF04, 2, 1, 32'hCAFE_F00D, 10, 1, 32'h0, 0,
                 4'b1111, 32'hCAFE_F00D, 11, 0, 0, 32'h1122);
    tbl[5]  = mk(32'hFFFF_FF02, 2, 0, 32'h0, 0, 1, 32'h1122_3344, 0,
                 4'b0000, 32'h0, 0, 1, 0, 32'h0);
    tbl[6]  = mk(32'hFFFF_FF01, 0, 0, 32'h0, 0, 0, 32'h1122_3344, 0,
                 4'b0100, 32'h0, 1, 0, 1, 32'h0);
    tbl[7]  = mk(32'hFFFF_FF08, 2, 0, 32'h0, 100, 1, 32'h1122_3344, 1,
                 4'b1111, 32'h0, 4, 0, 1, 32'h0);
    tbl[8]  = mk(32'hFFFF_FF02, 1, 0, 32'h0, 3, 1, 32'h1122_3344, 1,
                 4'b0011, 32'h0, 4, 0, 0, 32'h3344);
    tbl[9]  = mk(32'hFFFF_FF02, 0, 1, 32'h0000_00A5, 0, 1, 32'h0, 0,
                 4'b0010, 32'hA5A5_A5A5, 1, 0, 0, 32'h0);
    tbl[10] = mk(32'hFFFF_FF0C, 3, 0, 32'h0, 0, 1, 32'h1122_3344, 0,
                 4'b1111, 32'h0, 1, 0, 0, 32'h1122_3344);
    tbl[11] = mk(32'hFFFF_FF01, 1, 0, 32'h0, 0, 1, 32'h1122_3344, 0,
                 4'b0000, 32'h0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Enable / CE_R gating must freeze the timeout counter.
    sel = 1'b1;
    CPU_A = 32'hFFFF_FF10; CPU_SZ = 2; CPU_WE = 1'b0; CPU_DI = '0;
    IBUS_ACT = 1'b1; IBUS_BUSY = 1'b0; CPU_REQ = 1'b1;
    tick(1);
    IBUS_BUSY = 1'b1;
    tick(1);
    tick(1);
    chk("en_pre_req", 32'(o_req), 32'd1);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) tick(1);
    chk("en_off_req", {30'd0, o_req, o_ack}, 32'd2);
    EN = 1'b1;
    for (int i = 0; i < 3; i++) tick(0);
    chk("ce_off_req", {30'd0, o_req, o_ack}, 32'd2);
    tick(1);
    chk("en_s3_req", {30'd0, o_req, o_ack}, 32'd2);
    tick(1);
    chk("en_s4_abort", {29'd0, o_req, o_ack, o_berr}, 32'd3);
    CPU_REQ = 1'b0; IBUS_BUSY = 1'b0;
    tick(1);
    hold[1] = '0;

    // Reset in the middle of a busy access, with CE_R and EN low.
    sel = 1'b0;
    CPU_A = 32'hFFFF_FF20; CPU_SZ = 2; CPU_WE = 1'b1;
    CPU_DI = 32'h5555_AAAA; IBUS_ACT = 1'b1; CPU_REQ = 1'b1;
    tick(1);
    IBUS_BUSY = 1'b1;
    tick(1);
    tick(1);
    chk("rst_pre_req", 32'(o_req), 32'd1);
    CPU_REQ = 1'b0; RST = 1'b1; EN = 1'b0;
    tick(0);
    chk("rst_mid_zero", 32'(|{do0, busy0, ack0, aerr0, berr0, a0, di0,
        ba0, we0, ireq0}), 32'd0);
    RST = 1'b0; EN = 1'b1; IBUS_BUSY = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (o_ack) acks_seen++;
    end
    chk("rst_no_ack", acks_seen, 0);
    hold[0] = '0;
    run(mk(32'hFFFF_FF24, 2, 0, 32'h0, 1, 1, 32'h8765_4321, 0,
           4'b1111, 32'h0, 2, 0, 0, 32'h8765_4321), "post_rst");

    for (int i = 0; i < 40; i++) begin
      rr.sel    = ($urandom % 4) == 0;
      rr.a      = $urandom;
      rr.sz     = 2'($urandom % 4);
      rr.we     = 1'($urandom % 2);
      rr.di     = $urandom;
      rr.act    = ($urandom % 8) != 0;
      rr.dov    = $urandom;
      rr.busy_n = rr.sel ? int'($urandom % 8) : int'($urandom % 7);
      rr = model(rr, hold[rr.sel]);
      run(rr, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
